rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter_pkg.sv | 18 +
 rtl/rr_grant_arbiter_mask_select.sv | 38 +++
 rtl/rr_grant_arbiter.sv | 97 +++++++++
 tb/tb_rr_grant_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_mask_select.sv
// Masked find-first winner select with wrap from a start pointer.
module rr_mask_select
  import rr_grant_arbiter_pkg::*;
#(
  parameter int W  = 5,
  parameter int PW = 3
) (
  input  logic [W-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic [W-1:0]  i_excl,
  output logic [W-1:0]  o_win,
  output logic          o_found
);

  logic [W-1:0]   cand;
  logic [W-1:0]   hi_mask;
  logic [2*W-1:0] dbl;

  always_comb begin
    cand    = i_req & ~i_excl;
    hi_mask = '0;
    for (int i = 0; i < W; i++) begin
      hi_mask[i] = (PW'(i) >= i_ptr);
    end
    // Upper copy covers the wrap back to index 0.
    dbl     = {cand, cand & hi_mask};
    o_win   = '0;
    o_found = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (dbl[i] && !o_found) begin
        o_found = 1'b1;
        if (i >= W) o_win[i-W] = 1'b1;
        else        o_win[i]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Grant-and-hold arbiter: IDLE/HOLD control, pointer and output registers.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int RR_MODE    = 1,
  localparam int IW        = clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_req,
  input  logic                  i_done,
  output logic [DATA_WIDTH-1:0] o_grant,
  output logic [IW-1:0]         o_grant_idx,
  output logic                  o_pmtFinish
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  fin_q, fin_d;

  logic                  rel;
  logic [DATA_WIDTH-1:0] excl;
  logic [DATA_WIDTH-1:0] win;
  logic                  found;
  logic [IW-1:0]         win_idx;

  rr_mask_select #(
    .W  (DATA_WIDTH),
    .PW (IW)
  ) u_sel (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .i_excl  (excl),
    .o_win   (win),
    .o_found (found)
  );

  always_comb begin
    rel = (state_q == HOLD) && (i_done || ~|(i_req & grant_q));
    // A sole remaining requester is re-granted, so only exclude it
    // when someone else is waiting.
    excl = '0;
    if (rel && |(i_req & ~grant_q)) excl = grant_q;
    win_idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (win[i]) win_idx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE || rel) begin
      if (found) begin
        state_d = HOLD;
        grant_d = win;
        idx_d   = win_idx;
        if (RR_MODE != 0) begin
          ptr_d = (win_idx == IW'(DATA_WIDTH - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          ptr_d = '0;
        end
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    end
    fin_d = |grant_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      fin_q   <= fin_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_pmtFinish = fin_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter, round-robin and fixed-priority.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, req_f;
  logic       done, done_f;
  logic [3:0] grant, grant_f;
  logic [1:0] idx, idx_f;
  logic       fin, fin_f;

  int n_pass;
  int n_total;

  rr_grant_arbiter #(.DATA_WIDTH(4), .RR_MODE(1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_done      (done),
    .o_grant     (grant),
    .o_grant_idx (idx),
    .o_pmtFinish (fin)
  );

  rr_grant_arbiter #(.DATA_WIDTH(4), .RR_MODE(0)) dut_fp (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req_f),
    .i_done      (done_f),
    .o_grant     (grant_f),
    .o_grant_idx (idx_f),
    .o_pmtFinish (fin_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req    = '0;
    done   = 1'b0;
    req_f  = '0;
    done_f = 1'b0;
    rst    = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req  = 4'b0101;
    rst  = 1'b1;
    step();
    n_total++;
    if ({grant, idx, fin} !== 7'b0000_00_0)
      $display("FAIL reset_rr: got %b/%0d/%b want 0000/0/0", grant, idx, fin);
    else n_pass++;
    n_total++;
    if ({grant_f, idx_f, fin_f} !== 7'b0000_00_0)
      $display("FAIL reset_fp: got %b/%0d/%b want 0000/0/0", grant_f, idx_f, fin_f);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0101;
    step();
    n_total++;
    if ({grant, idx, fin} !== 7'b0001_00_1)
      $display("FAIL basic_first: got %b/%0d/%b want 0001/0/1", grant, idx, fin);
    else n_pass++;
    done = 1'b1;
    step();
    done = 1'b0;
    n_total++;
    if ({grant, idx, fin} !== 7'b0100_10_1)
      $display("FAIL basic_b2b: got %b/%0d/%b want 0100/2/1", grant, idx, fin);
    else n_pass++;
    req = 4'b0000;
    step();
    n_total++;
    if ({grant, idx, fin} !== 7'b0000_00_0)
      $display("FAIL basic_idle: got %b/%0d/%b want 0000/0/0", grant, idx, fin);
    else n_pass++;
  endtask

  task automatic test_idle_done();
    do_reset();
    done = 1'b1;
    step();
    step();
    done = 1'b0;
    n_total++;
    if ({grant, idx, fin} !== 7'b0000_00_0)
      $display("FAIL idle_done: got %b/%0d/%b want 0000/0/0", grant, idx, fin);
    else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b1110;
    req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({grant, idx, fin} !== 7'b0001_00_1)
        $display("FAIL hold_%0d: got %b/%0d/%b want 0001/0/1", i, grant, idx, fin);
      else n_pass++;
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_g [5];
    logic [1:0] exp_i [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({grant, idx, fin} !== {exp_g[i], exp_i[i], 1'b1})
        $display("FAIL rotate_%0d: got %b/%0d want %b/%0d", i, grant, idx, exp_g[i], exp_i[i]);
      else n_pass++;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b1011;
    step();
    n_total++;
    if ({grant, idx, fin} !== 7'b1000_11_1)
      $display("FAIL withdraw: got %b/%0d/%b want 1000/3/1", grant, idx, fin);
    else n_pass++;
    done = 1'b1;
    step();
    done = 1'b0;
    n_total++;
    if ({grant, idx} !== 6'b0001_00)
      $display("FAIL withdraw_ptr0: got %b/%0d want 0001/0", grant, idx);
    else n_pass++;
  endtask

  task automatic test_fixed();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    do_reset();
    req_f = 4'b0110;
    step();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (grant_f !== exp_g[i] || fin_f !== 1'b1)
        $display("FAIL fixed_%0d: got %b want %b", i, grant_f, exp_g[i]);
      else n_pass++;
      done_f = 1'b1;
      step();
      done_f = 1'b0;
    end
    req_f = 4'b0111;
    done_f = 1'b1;
    step();
    n_total++;
    if (grant_f !== 4'b0001)
      $display("FAIL fixed_bit0: got %b want 0001", grant_f);
    else n_pass++;
    step();
    step();
    done_f = 1'b0;
    n_total++;
    if ({grant_f, idx_f} !== 6'b0001_00)
      $display("FAIL fixed_prio: got %b/%0d want 0001/0", grant_f, idx_f);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req  = 4'b0100;
    done = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({grant, idx, fin} !== 7'b0100_10_1)
        $display("FAIL single_%0d: got %b/%0d/%b want 0100/2/1", i, grant, idx, fin);
      else n_pass++;
      step();
    end
    done = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b1000;
    step();
    n_total++;
    if (grant !== 4'b1000)
      $display("FAIL midrst_pre: got %b want 1000", grant);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({grant, idx, fin} !== 7'b0000_00_0)
      $display("FAIL midrst_async: got %b/%0d/%b want 0000/0/0", grant, idx, fin);
    else n_pass++;
    req = 4'b1001;
    step();
    rst = 1'b0;
    step();
    n_total++;
    if ({grant, idx, fin} !== 7'b0001_00_1)
      $display("FAIL midrst_after: got %b/%0d/%b want 0001/0/1", grant, idx, fin);
    else n_pass++;
    do_reset();
    req = 4'b0010;
    step();
    rst = 1'b1;
    req = 4'b1011;
    step();
    rst = 1'b0;
    step();
    n_total++;
    if (grant !== 4'b0001)
      $display("FAIL midrst_ptr: got %b want 0001", grant);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    req     = '0;
    done    = 1'b0;
    req_f   = '0;
    done_f  = 1'b0;
    test_reset();
    test_basic();
    test_idle_done();
    test_hold();
    test_rotate();
    test_withdraw();
    test_fixed();
    test_single();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
